// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns debounced run/step keys and PC breakpoints into a
// one-cycle CPU clock enable, and keeps a saturating count of enables issued.
module cpu_run_ctrl #(
    parameter int DIV      = 6_000_000,
    parameter int DEBOUNCE = 500_000,
    parameter int PC_WIDTH = 16,
    parameter int NUM_BP   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_key_n,
    input  logic                       step_key_n,
    input  logic [PC_WIDTH-1:0]        pc_count,
    input  logic [NUM_BP-1:0]          bp_en,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    output logic                       cpu_en,
    output logic [1:0]                 run_state,
    output logic [NUM_BP-1:0]          bp_hit,
    output logic [CNT_W-1:0]           instr_count
);
    localparam int DIV_W = $clog2(DIV);
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam int KEY_RUN  = 0;
    localparam int KEY_STEP = 1;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    function automatic logic [NUM_BP-1:0] bp_match(
        input logic [PC_WIDTH-1:0]        pc,
        input logic [NUM_BP-1:0]          en,
        input logic [NUM_BP*PC_WIDTH-1:0] addr
    );
        logic [NUM_BP-1:0] m;
        m = {NUM_BP{1'b0}};
        for (int i = 0; i < NUM_BP; i++) begin
            m[i] = en[i] & (pc == addr[i*PC_WIDTH +: PC_WIDTH]);
        end
        return m;
    endfunction

    logic [1:0]        key_raw_s;
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        deb_r;
    logic [1:0]        deb_d_r;
    logic [DB_W-1:0]   db_cnt_r [2];
    logic [1:0]        press_s;

    state_t            state_r;
    logic [DIV_W-1:0]  div_r;
    logic              skip_r;
    logic              cpu_en_r;
    logic [NUM_BP-1:0] bp_hit_r;
    logic [CNT_W-1:0]  count_r;
    logic              tick_s;
    logic [NUM_BP-1:0] match_s;

    assign key_raw_s = {step_key_n, run_key_n};
    // Press fires the cycle after the debounced level falls; release is silent.
    assign press_s   = deb_d_r & ~deb_r;
    assign tick_s    = (div_r == DIV_LAST);
    assign match_s   = bp_match(pc_count, bp_en, bp_addr);

    // Synchronise both keys and accept a level only after DEBOUNCE differing cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
            deb_r   <= 2'b11;
            deb_d_r <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt_r[k] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= key_raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int k = 0; k < 2; k++) begin
                if (sync2_r[k] == deb_r[k]) begin
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end else if (db_cnt_r[k] == DB_LAST) begin
                    deb_r[k]    <= sync2_r[k];
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
                end
            end
        end
    end

    // Run-mode FSM with divider, breakpoint capture and registered enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_HALT;
            div_r    <= {DIV_W{1'b0}};
            skip_r   <= 1'b0;
            cpu_en_r <= 1'b0;
            bp_hit_r <= {NUM_BP{1'b0}};
        end else begin
            cpu_en_r <= 1'b0;
            case (state_r)
                ST_HALT: begin
                    div_r <= {DIV_W{1'b0}};
                    if (press_s[KEY_RUN]) begin
                        state_r <= ST_RUN;
                    end else if (press_s[KEY_STEP]) begin
                        state_r  <= ST_STEP;
                        cpu_en_r <= 1'b1;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    div_r   <= {DIV_W{1'b0}};
                    state_r <= ST_HALT;
                end
                ST_RUN: begin
                    if (press_s[KEY_RUN]) begin
                        state_r <= ST_HALT;
                        div_r   <= {DIV_W{1'b0}};
                    end else if (tick_s) begin
                        div_r <= {DIV_W{1'b0}};
                        // A resumed breakpoint is skipped once so the CPU can move past it.
                        if ((|match_s) && !skip_r) begin
                            state_r  <= ST_BREAK;
                            bp_hit_r <= match_s;
                        end else begin
                            cpu_en_r <= 1'b1;
                            skip_r   <= 1'b0;
                        end
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_BREAK: begin
                    div_r <= {DIV_W{1'b0}};
                    if (press_s[KEY_RUN]) begin
                        state_r  <= ST_RUN;
                        skip_r   <= 1'b1;
                        bp_hit_r <= {NUM_BP{1'b0}};
                    end else if (press_s[KEY_STEP]) begin
                        state_r  <= ST_STEP;
                        cpu_en_r <= 1'b1;
                        bp_hit_r <= {NUM_BP{1'b0}};
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r  <= ST_HALT;
                    div_r    <= {DIV_W{1'b0}};
                    bp_hit_r <= {NUM_BP{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of enables issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cpu_en_r && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign cpu_en      = cpu_en_r;
    assign run_state   = state_r;
    assign bp_hit      = bp_hit_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random key/PC traffic, all
// compared each cycle against a behavioural model of the run controller.
module tb_cpu_run_ctrl;
    localparam int DIV      = 4;
    localparam int DEBOUNCE = 3;
    localparam int PC_WIDTH = 16;
    localparam int NUM_BP   = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int HN       = DEBOUNCE + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_key_n;
    logic        step_key_n;
    logic [15:0] pc_count;
    logic [1:0]  bp_en;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic [1:0]  run_state;
    logic [1:0]  bp_hit;
    logic [3:0]  instr_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // model state: mode uses the output encoding 0=HALT 1=RUN 2=STEP 3=BREAK
    int       m_state;
    int       m_wait;
    bit       m_skip;
    bit       m_en;
    int       m_count;
    logic [1:0] m_hit;
    bit       hist [2][HN];
    bit       m_deb [2];
    bit       m_pend [2];

    bit       pc_auto = 1'b0;
    int       en_seen = 0;
    logic [15:0] first_en_pc;

    cpu_run_ctrl #(
        .DIV(DIV), .DEBOUNCE(DEBOUNCE), .PC_WIDTH(PC_WIDTH), .NUM_BP(NUM_BP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run_key_n(run_key_n), .step_key_n(step_key_n),
        .pc_count(pc_count), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en), .run_state(run_state), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_skip = 1'b0; m_en = 1'b0; m_count = 0; m_hit = 2'b00;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < HN; i++) hist[k][i] = 1'b1;
            m_deb[k]  = 1'b1;
            m_pend[k] = 1'b0;
        end
    endtask

    // What the controller does at the coming clock edge, given current inputs.
    task automatic model_edge();
        bit ev [2];
        bit raw [2];
        bit settled;
        logic [1:0] match;
        raw[0] = run_key_n;
        raw[1] = step_key_n;
        for (int k = 0; k < 2; k++) begin
            ev[k] = m_pend[k];
            m_pend[k] = 1'b0;
            for (int i = 0; i < HN - 1; i++) hist[k][i] = hist[k][i+1];
            hist[k][HN-1] = raw[k];
            // the oldest DEBOUNCE samples have cleared the synchroniser
            settled = 1'b1;
            for (int i = 0; i < DEBOUNCE; i++) if (hist[k][i] == m_deb[k]) settled = 1'b0;
            if (settled) begin
                m_deb[k]  = !m_deb[k];
                m_pend[k] = !m_deb[k];
            end
        end
        if (m_en && m_count < CNT_MAX) m_count++;
        m_en = 1'b0;
        case (m_state)
            0: if (ev[0]) begin m_state = 1; m_wait = DIV; end
               else if (ev[1]) begin m_state = 2; m_en = 1'b1; end
            2: m_state = 0;
            1: if (ev[0]) m_state = 0;
               else begin
                   m_wait--;
                   if (m_wait == 0) begin
                       m_wait = DIV;
                       for (int i = 0; i < NUM_BP; i++)
                           match[i] = bp_en[i] && (pc_count == bp_addr[i*PC_WIDTH +: PC_WIDTH]);
                       if (match != 2'b00 && !m_skip) begin m_state = 3; m_hit = match; end
                       else begin m_en = 1'b1; m_skip = 1'b0; end
                   end
               end
            3: if (ev[0]) begin m_state = 1; m_wait = DIV; m_skip = 1'b1; m_hit = 2'b00; end
               else if (ev[1]) begin m_state = 2; m_en = 1'b1; m_hit = 2'b00; end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("cpu_en", 32'(cpu_en), 32'(m_en));
        check("run_state", 32'(run_state), 32'(m_state));
        check("bp_hit", 32'(bp_hit), 32'(m_hit));
        check("instr_count", 32'(instr_count), 32'(m_count));
        if (cpu_en) begin
            if (en_seen == 0) first_en_pc = pc_count;
            en_seen++;
            if (pc_auto) pc_count = pc_count + 16'd1;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_state"}, 32'(run_state), 32'd0);
        check({tag, "_bp_hit"}, 32'(bp_hit), 32'd0);
        check({tag, "_count"}, 32'(instr_count), 32'd0);
    endtask

    task automatic do_reset();
        run_key_n = 1'b1;
        step_key_n = 1'b1;
        reset = 1'b0;
        model_reset();
        #1;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int first_run;
        int run_hold;
        int step_hold;
        bit saw_step;
        bit found;
        pc_count = 16'd0;
        bp_en = 2'b00;
        bp_addr = 32'd0;
        do_reset();

        // 1: idle after reset
        en_seen = 0;
        cycles(100);
        check("idle_no_en", 32'(en_seen), 32'd0);

        // 2: short glitch ignored, then held press enters RUN 6 cycles later
        run_key_n = 1'b0;
        cycles(2);
        run_key_n = 1'b1;
        cycles(10);
        check("glitch_state", 32'(run_state), 32'd0);
        run_key_n = 1'b0;
        first_run = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (run_state == 2'd1 && first_run < 0) first_run = i;
        end
        run_key_n = 1'b1;
        check("run_latency", 32'(first_run), 32'd6);
        en_seen = 0;
        cycles(20);
        check("run_en_rate", 32'(en_seen), 32'd5);
        step_key_n = 1'b0;
        cycles(8);
        step_key_n = 1'b1;
        cycles(10);
        check("step_in_run", 32'(run_state), 32'd1);

        // 3: single step from HALT
        do_reset();
        en_seen = 0;
        saw_step = 1'b0;
        step_key_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) step_key_n = 1'b1;
            cycle();
            if (run_state == 2'd2) saw_step = 1'b1;
        end
        check("step_pulses", 32'(en_seen), 32'd1);
        check("step_seen", 32'(saw_step), 32'd1);
        check("step_back_halt", 32'(run_state), 32'd0);
        check("step_count", 32'(instr_count), 32'd1);

        // 4: breakpoint at pc 3, then resume past it
        do_reset();
        bp_en = 2'b01;
        bp_addr = {16'h0040, 16'h0003};
        pc_count = 16'd0;
        pc_auto = 1'b1;
        run_key_n = 1'b0;
        cycles(8);
        run_key_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            if (run_state == 2'd3) found = 1'b1;
        end
        check("bp_reached", 32'(found), 32'd1);
        check("bp_hit_vec", 32'(bp_hit), 32'd1);
        check("bp_pc", 32'(pc_count), 32'd3);
        cycles(5);
        en_seen = 0;
        run_key_n = 1'b0;
        cycles(8);
        run_key_n = 1'b1;
        for (int i = 0; i < 50 && en_seen == 0; i++) cycle();
        check("resume_en", 32'(en_seen > 0), 32'd1);
        check("resume_pc", 32'(first_en_pc), 32'd3);
        check("resume_hit_clr", 32'(bp_hit), 32'd0);
        cycles(20);
        check("resume_running", 32'(run_state), 32'd1);
        pc_auto = 1'b0;

        // 5: saturation, then simultaneous run+step from HALT
        do_reset();
        for (int s = 0; s < 20; s++) begin
            step_key_n = 1'b0;
            cycles(5);
            step_key_n = 1'b1;
            cycles(5);
        end
        cycles(5);
        check("saturate", 32'(instr_count), 32'd15);
        saw_step = 1'b0;
        run_key_n = 1'b0;
        step_key_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin run_key_n = 1'b1; step_key_n = 1'b1; end
            cycle();
            if (run_state == 2'd2) saw_step = 1'b1;
        end
        check("both_no_step", 32'(saw_step), 32'd0);
        check("both_run", 32'(run_state), 32'd1);

        // 6: asynchronous reset during an enable pulse
        en_seen = 0;
        for (int i = 0; i < 20 && en_seen == 0; i++) cycle();
        check("pulse_before_rst", 32'(cpu_en), 32'd1);
        reset = 1'b0;
        #1;
        reset_checks("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // random traffic
        run_hold = 0;
        step_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_hold == 0) begin
                run_key_n = 1'($urandom_range(0, 1));
                run_hold = $urandom_range(1, 10);
            end
            if (step_hold == 0) begin
                step_key_n = 1'($urandom_range(0, 1));
                step_hold = $urandom_range(1, 10);
            end
            run_hold--;
            step_hold--;
            pc_count = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                bp_en = 2'($urandom_range(0, 3));
                bp_addr = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
            end
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
